multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT, default 15: the maximum number of consecutive memory-wait cycles before a fault, legal range 1..255.
REQ-002 clk  input  1  rising-edge clock; all state updates occur on this edge only.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 opcode  input  6  instruction bits [31:26], taken from the datapath instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  the shared instruction/data memory completes the current access this cycle.
REQ-007 The Moore strobes are pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write and alu_src_a, each an output, 1 bit wide.
REQ-008 alu_src_b  output  2  selects 00=B reg, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-009 alu_op  output  2  selects 00=add, 01=sub, 10=use funct.
REQ-010 pc_source  output  2  selects 00=ALU result, 01=ALUOut reg, 10={PC[31:28],instr[25:0],2'b00}.
REQ-011 fault  output  1  sticky memory-timeout/illegal-opcode flag.
REQ-012 state  output  4  current state encoding, provided for debug.

Function
REQ-013 The states shall be encoded as FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, HALT=12; codes 13-15 shall go to HALT and set fault.
REQ-014 All outputs except state and fault shall be decoded combinationally from the current state plus mem_ready/zero; any output not listed for a state shall be 0.
REQ-015 FETCH shall drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01 and alu_op=00; ir_write, pc_write and the advance to DECODE shall occur only when mem_ready=1, otherwise the block shall hold in FETCH.
REQ-016 DECODE shall drive alu_src_a=0, alu_src_b=11 and alu_op=00, then branch on opcode: 100011/101011 to MEM_ADDR, 000000 to R_EXEC, 000100 to BRANCH, 000010 to JUMP, 001000 to I_EXEC, and any other value to HALT with fault set.
REQ-017 MEM_ADDR shall drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to MEM_RD for opcode 100011 and to MEM_WR for opcode 101011.
REQ-018 MEM_RD shall drive mem_read=1 and i_or_d=1, advancing to MEM_WB on mem_ready=1 and holding otherwise.
REQ-019 MEM_WB shall drive reg_write=1, mem_to_reg=1 and reg_dst=0, then return to FETCH.
REQ-020 MEM_WR shall drive mem_write=1 and i_or_d=1, advancing to FETCH on mem_ready=1 and holding otherwise; mem_write shall stay asserted throughout the hold.
REQ-021 R_EXEC shall drive alu_src_a=1, alu_src_b=00 and alu_op=10, then go to R_WB, which shall drive reg_write=1, reg_dst=1 and mem_to_reg=0 and then go to FETCH.
REQ-022 BRANCH shall drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1 and pc_source=01, then go to FETCH; the PC update shall be the datapath's pc_write | (pc_write_cond & zero) and is not gated by this block.
REQ-023 JUMP shall drive pc_write=1 and pc_source=10, then go to FETCH.
REQ-024 I_EXEC shall drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to I_WB, which shall drive reg_write=1, reg_dst=0 and mem_to_reg=0 and then go to FETCH.
REQ-025 An 8-bit wait counter shall increment each cycle spent in FETCH/MEM_RD/MEM_WR with mem_ready=0 and shall clear on mem_ready=1 or on entry to any other state.
REQ-026 When the counter equals TIMEOUT while mem_ready=0, the next state shall be HALT and fault shall be set; a mem_ready=1 arriving in that same cycle shall take precedence, giving a normal advance with no fault.
REQ-027 HALT shall drive all strobes 0 and shall be left only by rst; fault shall remain 1 until rst.
REQ-028 Instruction latency with zero wait cycles shall be: lw 5, sw 4, R-type 4, addi 4, beq 3 and j 3 cycles.

Reset
REQ-029 A rst=1 at a rising edge shall set state=FETCH, wait counter=0 and fault=0, and shall override every transition, including from HALT and mid-instruction.
REQ-030 While rst=1, all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write and reg_write) shall be forced to 0 combinationally.

Verification
REQ-031 The bench shall hold rst for 2 cycles, release it, and apply mem_ready=1 with opcode 100011; state shall read 0,1,2,3,4,0, with reg_write=1 and mem_to_reg=1 only in state 4.
REQ-032 The bench shall issue beq with zero=1 and then with zero=0; pc_write_cond=1 and pc_source=01 shall appear in state 8 both times, and the sequence shall take 3 cycles.
REQ-033 The bench shall run sw with mem_ready low for 3 cycles in MEM_WR; mem_write shall be held for 4 cycles, followed by FETCH and fault=0.
REQ-034 With TIMEOUT=15 and mem_ready held 0 in FETCH, the block shall move to HALT after the count reaches 15, set fault=1 and keep all strobes 0 until rst.
REQ-035 The bench shall apply opcode 111111 in DECODE; the block shall enter HALT with fault=1, and a later rst shall restore FETCH with fault=0.
REQ-036 The bench shall assert rst while the block is in R_EXEC; on the next cycle state shall be 0 and reg_write shall never be asserted.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit (lw, sw, R-type, beq, j, addi).
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   opcode[5:0]       instruction bits [31:26] from the instruction register
//   zero              ALU zero flag (the datapath does the PC gating itself)
//   mem_ready         shared memory finishes the current access this cycle
//   pc_write .. alu_src_a   1-bit Moore strobes/selects for the datapath
//   alu_src_b[1:0]    00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
//   alu_op[1:0]       00=add, 01=sub, 10=use funct
//   pc_source[1:0]    00=ALU result, 01=ALUOut, 10=jump target
//   fault             sticky memory-timeout / illegal-opcode flag
//   state[3:0]        current state encoding, for debug
module multicycle_control #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11,
    HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       fault_reg, fault_next;
  logic       in_wait;

  // The branch decision is made in the datapath; zero is kept on the port
  // for interface completeness only.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= '0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      fault_reg    <= fault_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fault_next    = fault_reg;
    wait_cnt_next = '0;
    in_wait       = 1'b0;
    case (state_reg)
      FETCH: begin
        in_wait = 1'b1;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_RTYPE:     state_next = R_EXEC;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          OP_ADDI:      state_next = I_EXEC;
          default: begin
            state_next = HALT;
            fault_next = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        // opcode should not change mid-instruction; treat it as illegal if it does
        if (opcode == OP_LW)      state_next = MEM_RD;
        else if (opcode == OP_SW) state_next = MEM_WR;
        else begin
          state_next = HALT;
          fault_next = 1'b1;
        end
      end
      MEM_RD: begin
        in_wait = 1'b1;
        if (mem_ready) state_next = MEM_WB;
      end
      MEM_WB: state_next = FETCH;
      MEM_WR: begin
        in_wait = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      R_EXEC: state_next = R_WB;
      R_WB:   state_next = FETCH;
      BRANCH: state_next = FETCH;
      JUMP:   state_next = FETCH;
      I_EXEC: state_next = I_WB;
      I_WB:   state_next = FETCH;
      HALT:   state_next = HALT;
      default: begin
        state_next = HALT;
        fault_next = 1'b1;
      end
    endcase

    // A stalled memory state counts up; a ready access always wins over the
    // timeout, and every other state leaves the counter cleared.
    if (in_wait && !mem_ready) begin
      if (wait_cnt_reg == TIMEOUT_W) begin
        state_next = HALT;
        fault_next = 1'b1;
      end else begin
        wait_cnt_next = wait_cnt_reg + 8'd1;
      end
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_reg)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: alu_src_b = 2'b11;
      MEM_ADDR, I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      I_WB: reg_write = 1'b1;
      default: ;
    endcase

    // Reset masks every state-changing strobe before the register clears.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
    end
  end

  assign fault = fault_reg;
  assign state = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       fault;
  logic [3:0] state;

  multicycle_control #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  logic [15:0] act_w;
  assign act_w = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  localparam logic [15:0] W_FETCH_RDY  = 16'h9410;
  localparam logic [15:0] W_FETCH_WAIT = 16'h1010;
  localparam logic [15:0] W_FETCH_RST  = 16'h0010;
  localparam logic [15:0] W_DECODE     = 16'h0030;
  localparam logic [15:0] W_MEM_ADDR   = 16'h0060;
  localparam logic [15:0] W_MEM_RD     = 16'h3000;
  localparam logic [15:0] W_MEM_WB     = 16'h0280;
  localparam logic [15:0] W_MEM_WR     = 16'h2800;
  localparam logic [15:0] W_R_EXEC     = 16'h0048;
  localparam logic [15:0] W_R_WB       = 16'h0180;
  localparam logic [15:0] W_BRANCH     = 16'h4045;
  localparam logic [15:0] W_JUMP       = 16'h8002;
  localparam logic [15:0] W_I_EXEC     = 16'h0060;
  localparam logic [15:0] W_I_WB       = 16'h0080;
  localparam logic [15:0] W_HALT       = 16'h0000;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct packed {
    logic [3:0]  st;
    logic        flt;
    logic [15:0] w;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  // Drive one cycle of inputs, queue the outputs expected during that cycle.
  task automatic cyc(input logic r, input logic mr, input logic z, input logic [5:0] opc,
                     input logic [3:0] es, input logic ef, input logic [15:0] ew,
                     input string nm);
    exp_t e;
    rst = r; mem_ready = mr; zero = z; opcode = opc;
    e.st = es; e.flt = ef; e.w = ew;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (state !== e.st || fault !== e.flt || act_w !== e.w) begin
        failures++;
        $display("FAIL %s: got state=%0d fault=%b ctl=%h, want state=%0d fault=%b ctl=%h",
                 nm, state, fault, act_w, e.st, e.flt, e.w);
      end else begin
        $display("ok   %s: state=%0d fault=%b ctl=%h", nm, state, fault, act_w);
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // second reset cycle: state already FETCH, strobes masked
    cyc(1, 1, 0, LW, 4'd0, 0, W_FETCH_RST, "reset");

    // lw, no waits: 0,1,2,3,4 then FETCH
    cyc(0, 1, 0, LW, 4'd0, 0, W_FETCH_RDY, "lw_fetch");
    cyc(0, 1, 0, LW, 4'd1, 0, W_DECODE,    "lw_decode");
    cyc(0, 1, 0, LW, 4'd2, 0, W_MEM_ADDR,  "lw_addr");
    cyc(0, 1, 0, LW, 4'd3, 0, W_MEM_RD,    "lw_rd");
    cyc(0, 1, 0, LW, 4'd4, 0, W_MEM_WB,    "lw_wb");

    // beq taken and not taken: same control, 3 cycles each
    cyc(0, 1, 1, BEQ, 4'd0, 0, W_FETCH_RDY, "beq1_fetch");
    cyc(0, 1, 1, BEQ, 4'd1, 0, W_DECODE,    "beq1_decode");
    cyc(0, 1, 1, BEQ, 4'd8, 0, W_BRANCH,    "beq1_branch");
    cyc(0, 1, 0, BEQ, 4'd0, 0, W_FETCH_RDY, "beq0_fetch");
    cyc(0, 1, 0, BEQ, 4'd1, 0, W_DECODE,    "beq0_decode");
    cyc(0, 1, 0, BEQ, 4'd8, 0, W_BRANCH,    "beq0_branch");

    // sw with 3 wait cycles in MEM_WR: mem_write held 4 cycles
    cyc(0, 1, 0, SW, 4'd0, 0, W_FETCH_RDY, "sw_fetch");
    cyc(0, 1, 0, SW, 4'd1, 0, W_DECODE,    "sw_decode");
    cyc(0, 1, 0, SW, 4'd2, 0, W_MEM_ADDR,  "sw_addr");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, SW, 4'd5, 0, W_MEM_WR, "sw_wr_wait");
    cyc(0, 1, 0, SW, 4'd5, 0, W_MEM_WR,    "sw_wr_done");

    // R-type
    cyc(0, 1, 0, RT, 4'd0, 0, W_FETCH_RDY, "r_fetch");
    cyc(0, 1, 0, RT, 4'd1, 0, W_DECODE,    "r_decode");
    cyc(0, 1, 0, RT, 4'd6, 0, W_R_EXEC,    "r_exec");
    cyc(0, 1, 0, RT, 4'd7, 0, W_R_WB,      "r_wb");

    // addi
    cyc(0, 1, 0, ADDI, 4'd0,  0, W_FETCH_RDY, "addi_fetch");
    cyc(0, 1, 0, ADDI, 4'd1,  0, W_DECODE,    "addi_decode");
    cyc(0, 1, 0, ADDI, 4'd10, 0, W_I_EXEC,    "addi_exec");
    cyc(0, 1, 0, ADDI, 4'd11, 0, W_I_WB,      "addi_wb");

    // j
    cyc(0, 1, 0, JMP, 4'd0, 0, W_FETCH_RDY, "j_fetch");
    cyc(0, 1, 0, JMP, 4'd1, 0, W_DECODE,    "j_decode");
    cyc(0, 1, 0, JMP, 4'd9, 0, W_JUMP,      "j_jump");

    // lw with stalls in FETCH and MEM_RD
    cyc(0, 0, 0, LW, 4'd0, 0, W_FETCH_WAIT, "lws_fetch_wait");
    cyc(0, 0, 0, LW, 4'd0, 0, W_FETCH_WAIT, "lws_fetch_wait");
    cyc(0, 1, 0, LW, 4'd0, 0, W_FETCH_RDY,  "lws_fetch");
    cyc(0, 1, 0, LW, 4'd1, 0, W_DECODE,     "lws_decode");
    cyc(0, 1, 0, LW, 4'd2, 0, W_MEM_ADDR,   "lws_addr");
    cyc(0, 0, 0, LW, 4'd3, 0, W_MEM_RD,     "lws_rd_wait");
    cyc(0, 0, 0, LW, 4'd3, 0, W_MEM_RD,     "lws_rd_wait");
    cyc(0, 1, 0, LW, 4'd3, 0, W_MEM_RD,     "lws_rd");
    cyc(0, 1, 0, LW, 4'd4, 0, W_MEM_WB,     "lws_wb");

    // mem_ready arriving exactly when the count hits TIMEOUT wins
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, JMP, 4'd0, 0, W_FETCH_WAIT, "edge_fetch_wait");
    cyc(0, 1, 0, JMP, 4'd0, 0, W_FETCH_RDY, "edge_fetch_rdy");
    cyc(0, 1, 0, JMP, 4'd1, 0, W_DECODE,    "edge_decode");
    cyc(0, 1, 0, JMP, 4'd9, 0, W_JUMP,      "edge_jump");

    // real timeout: 16 stalled FETCH cycles (count 0..15), then HALT
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, LW, 4'd0, 0, W_FETCH_WAIT, "to_fetch_wait");
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, LW, 4'd12, 1, W_HALT, "to_halt");
    cyc(1, 1, 0, LW, 4'd12, 1, W_HALT,      "to_halt_rst");
    cyc(0, 1, 0, LW, 4'd0,  0, W_FETCH_RDY, "to_recover");

    // illegal opcode in DECODE
    cyc(0, 1, 0, BAD, 4'd1,  0, W_DECODE, "ill_decode");
    cyc(0, 1, 0, BAD, 4'd12, 1, W_HALT,   "ill_halt");
    cyc(0, 0, 0, BAD, 4'd12, 1, W_HALT,   "ill_halt_hold");
    cyc(1, 1, 0, LW,  4'd12, 1, W_HALT,   "ill_halt_rst");
    cyc(0, 1, 0, RT,  4'd0,  0, W_FETCH_RDY, "ill_recover");

    // reset while in R_EXEC: FETCH next, R_WB never reached
    cyc(0, 1, 0, RT, 4'd1, 0, W_DECODE,    "rr_decode");
    cyc(1, 1, 0, RT, 4'd6, 0, W_R_EXEC,    "rr_exec_rst");
    cyc(0, 0, 0, RT, 4'd0, 0, W_FETCH_WAIT, "rr_fetch");

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
